// File: rtl/mp_register_file_pkg.sv
// mp_register_file_pkg: shared defaults, register-address type and index-width helper
package mp_register_file_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_AW = $clog2(DEF_NUM_REGS);
  typedef logic [DEF_AW-1:0] reg_addr_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mp_regfile_warb.sv
// mp_regfile_warb: per-register write enable and winning write-port index (highest port wins)
module mp_regfile_warb import mp_register_file_pkg::*; #(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_WPORTS = 2,
  parameter int AW = $clog2(NUM_REGS),
  parameter int WIW = idx_w(NUM_WPORTS)
) (
  input  logic [NUM_WPORTS-1:0]          we,
  input  logic [NUM_WPORTS-1:0][AW-1:0]  waddr,
  output logic [NUM_REGS-1:0]            wen,
  output logic [NUM_REGS-1:0][WIW-1:0]   wsel
);
  always_comb begin
    wen = '0;
    wsel = '0;
    for (int w = 0; w < NUM_WPORTS; w++) begin
      if (we[w] && waddr[w] != '0) begin
        wen[waddr[w]] = 1'b1;
        wsel[waddr[w]] = WIW'(w);
      end
    end
  end
endmodule

// File: rtl/mp_register_file.sv
// mp_register_file: multi-port register file with pending bits; MP_REGFILE_BYPASS_EN adds write-to-read forwarding
module mp_register_file import mp_register_file_pkg::*; #(
  parameter int XLEN = DEF_XLEN,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RPORTS = 2,
  parameter int NUM_WPORTS = 2
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst,
  input  logic [NUM_WPORTS-1:0]                     i_we,
  input  logic [NUM_WPORTS-1:0][$clog2(NUM_REGS)-1:0] i_waddr,
  input  logic [NUM_WPORTS-1:0][XLEN-1:0]           i_wdata,
  input  logic [NUM_RPORTS-1:0][$clog2(NUM_REGS)-1:0] i_raddr,
  output logic [NUM_RPORTS-1:0][XLEN-1:0]           o_rdata,
  output logic [NUM_RPORTS-1:0]                     o_rbusy,
  input  logic                                      i_rsv,
  input  logic [$clog2(NUM_REGS)-1:0]               i_rsv_addr,
  output logic                                      o_rsv_ok
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int WIW = idx_w(NUM_WPORTS);
  logic [NUM_REGS-1:0][XLEN-1:0] regs;
  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] wen;
  logic [NUM_REGS-1:0][WIW-1:0] wsel;
  mp_regfile_warb #(.NUM_REGS(NUM_REGS), .NUM_WPORTS(NUM_WPORTS), .AW(AW), .WIW(WIW)) u_warb (
    .we(i_we),
    .waddr(i_waddr),
    .wen(wen),
    .wsel(wsel)
  );
  // pend[0] never sets, so register 0 reservations are always accepted with no effect
  assign o_rsv_ok = i_rsv && (!pend[i_rsv_addr] || wen[i_rsv_addr]);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      regs <= '0;
      pend <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (wen[r]) regs[r] <= i_wdata[wsel[r]];
        pend[r] <= (o_rsv_ok && i_rsv_addr == AW'(r)) ? 1'b1 : wen[r] ? 1'b0 : pend[r];
      end
    end
  end
  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rd
`ifdef MP_REGFILE_BYPASS_EN
    logic byp;
    assign byp = !i_rst && wen[i_raddr[p]];
    assign o_rdata[p] = byp ? i_wdata[wsel[i_raddr[p]]] : regs[i_raddr[p]];
    assign o_rbusy[p] = !byp && pend[i_raddr[p]];
`else
    assign o_rdata[p] = regs[i_raddr[p]];
    assign o_rbusy[p] = pend[i_raddr[p]];
`endif
  end
endmodule

// File: tb/tb_mp_register_file.sv
// tb_mp_register_file: directed self-checking bench for mp_register_file (default parameters)
module tb_mp_register_file;
  import mp_register_file_pkg::*;
`ifdef MP_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic [1:0] i_we;
  reg_addr_t [1:0] i_waddr;
  logic [1:0][31:0] i_wdata;
  reg_addr_t [1:0] i_raddr;
  logic [1:0][31:0] o_rdata;
  logic [1:0] o_rbusy;
  logic i_rsv;
  reg_addr_t i_rsv_addr;
  logic o_rsv_ok;
  int checks = 0;
  int failures = 0;

  mp_register_file dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_we(i_we),
    .i_waddr(i_waddr),
    .i_wdata(i_wdata),
    .i_raddr(i_raddr),
    .o_rdata(o_rdata),
    .o_rbusy(o_rbusy),
    .i_rsv(i_rsv),
    .i_rsv_addr(i_rsv_addr),
    .o_rsv_ok(o_rsv_ok)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle;
    i_we = '0;
    i_waddr = '0;
    i_wdata = '0;
    i_rsv = 1'b0;
    i_rsv_addr = '0;
  endtask

  task automatic wr(input int port, input int addr, input logic [31:0] data);
    i_we[port] = 1'b1;
    i_waddr[port] = reg_addr_t'(addr);
    i_wdata[port] = data;
  endtask

  initial begin
    idle();
    i_raddr = '0;
    #2;
    i_raddr[0] = 5'd5;
    i_raddr[1] = 5'd7;
    #1;
    chk("reset_rdata0", o_rdata[0], 32'h0);
    chk("reset_rdata1", o_rdata[1], 32'h0);
    chk("reset_rbusy", {30'd0, o_rbusy}, 32'h0);
    @(negedge i_clk);
    i_rst = 1'b0;
    step();
    // write x5, read it back on port 1
    wr(0, 5, 32'hDEADBEEF);
    i_raddr[1] = 5'd5;
    #1;
    chk("x5_before_edge", o_rdata[1], BYP ? 32'hDEADBEEF : 32'h0);
    step();
    idle();
    #1;
    chk("x5_after_write", o_rdata[1], 32'hDEADBEEF);
    // x0 ignores writes
    wr(0, 0, 32'h1);
    step();
    idle();
    i_raddr[0] = 5'd0;
    #1;
    chk("x0_reads_zero", o_rdata[0], 32'h0);
    // same-address write conflict: highest port wins
    wr(0, 7, 32'h11);
    wr(1, 7, 32'h22);
    step();
    idle();
    i_raddr[0] = 5'd7;
    #1;
    chk("x7_port1_wins", o_rdata[0], 32'h22);
    // reservation flow on x3
    i_rsv = 1'b1;
    i_rsv_addr = 5'd3;
    i_raddr[0] = 5'd3;
    #1;
    chk("rsv_x3_ok", {31'd0, o_rsv_ok}, 32'h1);
    chk("x3_idle_before", {31'd0, o_rbusy[0]}, 32'h0);
    step();
    #1;
    chk("x3_busy", {31'd0, o_rbusy[0]}, 32'h1);
    chk("rsv_x3_refused", {31'd0, o_rsv_ok}, 32'h0);
    step();
    idle();
    #1;
    chk("x3_still_busy", {31'd0, o_rbusy[0]}, 32'h1);
    wr(1, 3, 32'h55);
    step();
    idle();
    #1;
    chk("x3_cleared", {31'd0, o_rbusy[0]}, 32'h0);
    chk("x3_data", o_rdata[0], 32'h55);
    // write and reserve x9 same cycle: reserve wins
    wr(0, 9, 32'h99);
    i_rsv = 1'b1;
    i_rsv_addr = 5'd9;
    i_raddr[1] = 5'd9;
    #1;
    chk("rsv_x9_ok", {31'd0, o_rsv_ok}, 32'h1);
    step();
    idle();
    #1;
    chk("x9_data", o_rdata[1], 32'h99);
    chk("x9_busy", {31'd0, o_rbusy[1]}, 32'h1);
    // reserve a pending register while it is being written: accepted
    wr(1, 9, 32'h77);
    i_rsv = 1'b1;
    i_rsv_addr = 5'd9;
    #1;
    chk("rsv_x9_while_write_ok", {31'd0, o_rsv_ok}, 32'h1);
    step();
    idle();
    #1;
    chk("x9_rewritten", o_rdata[1], 32'h77);
    chk("x9_busy_again", {31'd0, o_rbusy[1]}, 32'h1);
    // reserve x0: accepted, no effect
    i_rsv = 1'b1;
    i_rsv_addr = 5'd0;
    i_raddr[0] = 5'd0;
    #1;
    chk("rsv_x0_ok", {31'd0, o_rsv_ok}, 32'h1);
    step();
    idle();
    #1;
    chk("x0_not_busy", {31'd0, o_rbusy[0]}, 32'h0);
    // bypass versus stored value
    wr(0, 4, 32'h1234);
    step();
    idle();
    wr(1, 4, 32'hCAFE);
    i_raddr[0] = 5'd4;
    #1;
    chk("x4_same_cycle", o_rdata[0], BYP ? 32'hCAFE : 32'h1234);
    step();
    idle();
    #1;
    chk("x4_after_edge", o_rdata[0], 32'hCAFE);
    // fill x1..x4, reserve x2, then asynchronous reset between edges
    wr(0, 1, 32'h1);
    wr(1, 2, 32'h2);
    step();
    idle();
    wr(0, 3, 32'h3);
    wr(1, 4, 32'h4);
    i_rsv = 1'b1;
    i_rsv_addr = 5'd2;
    step();
    idle();
    i_raddr[0] = 5'd1;
    i_raddr[1] = 5'd2;
    #1;
    chk("fill_x1", o_rdata[0], 32'h1);
    chk("fill_x2_busy", {31'd0, o_rbusy[1]}, 32'h1);
    #1;
    i_rst = 1'b1;
    #1;
    chk("rst_x1", o_rdata[0], 32'h0);
    chk("rst_x2", o_rdata[1], 32'h0);
    chk("rst_busy12", {30'd0, o_rbusy}, 32'h0);
    i_raddr[0] = 5'd3;
    i_raddr[1] = 5'd4;
    #1;
    chk("rst_x3", o_rdata[0], 32'h0);
    chk("rst_x4", o_rdata[1], 32'h0);
    // writes and reservations during reset are not committed
    wr(0, 1, 32'h9);
    i_rsv = 1'b1;
    i_rsv_addr = 5'd2;
    i_raddr[0] = 5'd1;
    i_raddr[1] = 5'd2;
    #1;
    chk("rst_rsv_ok", {31'd0, o_rsv_ok}, 32'h1);
    chk("rst_no_bypass", o_rdata[0], 32'h0);
    step();
    idle();
    #1;
    chk("rst_no_write", o_rdata[0], 32'h0);
    chk("rst_no_rsv", {31'd0, o_rbusy[1]}, 32'h0);
    @(negedge i_clk);
    i_rst = 1'b0;
    wr(0, 1, 32'hAB);
    step();
    idle();
    #1;
    chk("post_rst_write", o_rdata[0], 32'hAB);
    chk("post_rst_idle", {30'd0, o_rbusy}, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mp_register_file.md
MP_REGISTER_FILE -- requirements
Module: mp_register_file

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NUM_REGS, default 32, register count; power of two, >= 2.
REQ-003 Parameter NUM_RPORTS, default 2, read port count, >= 1.
REQ-004 Parameter NUM_WPORTS, default 2, write port count, >= 1.
REQ-005 Port list SHALL be:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_we  in  [NUM_WPORTS]  per-port write enable.
- i_waddr  in  [NUM_WPORTS] x clog2(NUM_REGS)  write addresses.
- i_wdata  in  [NUM_WPORTS] x XLEN  write data.
- i_raddr  in  [NUM_RPORTS] x clog2(NUM_REGS)  read addresses.
- o_rdata  out  [NUM_RPORTS] x XLEN  read data.
- o_rbusy  out  [NUM_RPORTS]  addressed register has a pending producer.
- i_rsv  in  1  reserve request (mark destination pending).
- i_rsv_addr  in  clog2(NUM_REGS)  register to reserve.
- o_rsv_ok  out  1  reservation accepted this cycle.

Function
REQ-006 Register 0 SHALL read as zero, SHALL ignore writes, and SHALL never be marked pending.
REQ-007 Reads SHALL be combinational: o_rdata[p] reflects register state for i_raddr[p] in the same cycle.
REQ-008 Writes SHALL take effect at the rising edge of i_clk while i_we[w] is high and i_waddr[w] != 0.
REQ-009 If several enabled write ports target the same address in one cycle, the highest-numbered port SHALL win and all others to that address SHALL be discarded.
REQ-010 Each register SHALL have one pending bit; o_rbusy[p] SHALL equal the pending bit of i_raddr[p], combinationally.
REQ-011 An enabled write to register r SHALL clear its pending bit at the same edge.
REQ-012 o_rsv_ok SHALL be high, combinationally, when i_rsv is high, i_rsv_addr != 0 and the target pending bit is clear (or is being cleared by a write this cycle); the bit SHALL then be set at the edge.
REQ-013 A reservation of a pending register SHALL be refused (o_rsv_ok low) and SHALL leave state unchanged.
REQ-014 A same-cycle accepted reservation and write to the same register: data SHALL be written AND the pending bit SHALL end set (reserve wins).
REQ-015 A reservation of register 0 SHALL give o_rsv_ok high and SHALL have no state effect.

Reset
REQ-016 Asserting i_rst SHALL immediately, without clock, clear all registers to zero and all pending bits.
REQ-017 During reset, o_rdata SHALL be zero, o_rbusy low, and o_rsv_ok SHALL follow REQ-012 with all bits clear; no write or reservation SHALL be committed while i_rst is high.
REQ-018 Reset deassertion mid-sequence SHALL yield a fully idle file; first writes SHALL be accepted on the first edge after release.

Configuration
REQ-019 With macro MP_REGFILE_BYPASS_EN defined, a read port whose address matches an enabled, winning write this cycle SHALL return i_wdata of that port and o_rbusy low for that port.
REQ-020 Without MP_REGFILE_BYPASS_EN, reads SHALL return stored contents only; new data is visible the cycle after the write edge.

Structure
REQ-021 A shared package SHALL hold default XLEN/NUM_REGS constants and the register-address typedef, derived from clog2(NUM_REGS).
REQ-022 Write-port arbitration (per-register enable plus winning-port index) SHALL be one sub-module, mp_regfile_warb.
REQ-023 Storage and pending bits SHALL be flip-flops with asynchronous reset, no memory macros.

Verification
REQ-024 Write 0xDEADBEEF to x5 via port 0, next cycle read x5 on port 1 -> 0xDEADBEEF; write 0x1 to x0 -> x0 reads 0.
REQ-025 Ports 0 and 1 write 0x11/0x22 to x7 same cycle -> x7 reads 0x22.
REQ-026 Reserve x3 -> o_rsv_ok=1, then o_rbusy=1 on x3; second reserve of x3 -> o_rsv_ok=0; write 0x55 to x3 -> o_rbusy=0, data 0x55.
REQ-027 Write x9 and reserve x9 same cycle -> x9 = written data, o_rbusy=1 next cycle.
REQ-028 With MP_REGFILE_BYPASS_EN, write 0xCAFE to x4 while reading x4 -> same-cycle o_rdata=0xCAFE; without macro -> old value.
REQ-029 Fill x1..x4 and reserve x2, assert i_rst between edges -> all reads 0, all o_rbusy 0 immediately.
